// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line idle level.
// Also used by the transmit side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // Level of an idle serial line (mark).
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial input, fifo back-pressure and push/status outputs.
// master = the receiver driving the push side, slave = the consumer/line driver.
interface uart_rx_if #(
  parameter int data_width = 8
);

  logic                  rx;
  logic                  full;
  logic [data_width-1:0] data_out;
  logic                  data_valid;
  logic                  framing_error;
  logic                  parity_error;
  logic                  overrun_error;
  logic                  busy;

  modport master (
    input  rx,
    input  full,
    output data_out,
    output data_valid,
    output framing_error,
    output parity_error,
    output overrun_error,
    output busy
  );

  modport slave (
    output rx,
    output full,
    input  data_out,
    input  data_valid,
    input  framing_error,
    input  parity_error,
    input  overrun_error,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, one independent chain per bit.
// Flops reset to reset_value so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter int   width       = 1,
  parameter logic reset_value = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  for (genvar gi = 0; gi < width; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    // Two-stage capture of one asynchronous bit.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        meta_reg <= reset_value;
        sync_reg <= reset_value;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, data_width data bits LSB first, optional even parity, 1 stop.
// Pushes good bytes into a downstream fifo; false starts, framing, parity and
// overrun are detected and bad bytes are never pushed.
// Build option: define UART_PARITY_EN to expect an even-parity bit after the data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 434,
  parameter int data_width     = 8
) (
  input logic       clock,
  input logic       resetn,
  uart_rx_if.master bus
);

  localparam int cnt_w = $clog2(clocks_per_bit);
  localparam int idx_w = $clog2(data_width + 1);

  // Half a bit period after the falling edge puts all later samples mid-bit.
  localparam logic [cnt_w-1:0] cnt_half = cnt_w'(clocks_per_bit / 2 - 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clocks_per_bit - 1);
  localparam logic [idx_w-1:0] idx_last = idx_w'(data_width - 1);

  if (clocks_per_bit < 4) begin : g_cpb_check
    $error("uart_rx: clocks_per_bit must be >= 4");
  end

  uart_rx_state_t        state_reg;
  logic [cnt_w-1:0]      cnt_reg;
  logic [idx_w-1:0]      idx_reg;
  logic [data_width-1:0] shift_reg;
  logic [data_width-1:0] data_out_reg;
  logic                  data_valid_reg;
  logic                  framing_error_reg;
  logic                  parity_error_reg;
  logic                  overrun_error_reg;
  logic                  rx_s;
  logic                  parity_bad;

  sync_2ff #(
    .width       (1),
    .reset_value (UART_IDLE_LEVEL)
  ) u_rx_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (bus.rx),
    .q      (rx_s)
  );

`ifdef UART_PARITY_EN
  logic parity_bit_reg;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = ^{shift_reg, parity_bit_reg};
`else
  assign parity_bad = 1'b0;
`endif

  // Frame state machine with registered push and error pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      idx_reg           <= '0;
      shift_reg         <= '0;
      data_out_reg      <= '0;
      data_valid_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
      parity_error_reg  <= 1'b0;
      overrun_error_reg <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit_reg    <= 1'b0;
`endif
    end else begin
      data_valid_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
      parity_error_reg  <= 1'b0;
      overrun_error_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (rx_s != UART_IDLE_LEVEL) begin
            state_reg <= START;
          end
        end

        START: begin
          if (cnt_reg == cnt_half) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            // Line back high at mid start bit: treat as a glitch, silently.
            state_reg <= (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + cnt_w'(1);
          end
        end

        DATA: begin
          if (cnt_reg == cnt_last) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[data_width-1:1]};
            if (idx_reg == idx_last) begin
              idx_reg <= '0;
`ifdef UART_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              idx_reg <= idx_reg + idx_w'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + cnt_w'(1);
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt_reg == cnt_last) begin
            cnt_reg        <= '0;
            parity_bit_reg <= rx_s;
            state_reg      <= STOP;
          end else begin
            cnt_reg <= cnt_reg + cnt_w'(1);
          end
        end
`endif

        STOP: begin
          if (cnt_reg == cnt_last) begin
            cnt_reg <= '0;
            // Exactly one outcome, framing first, then parity, then overrun.
            if (rx_s != UART_IDLE_LEVEL) begin
              framing_error_reg <= 1'b1;
              state_reg         <= WAIT_IDLE;
            end else if (parity_bad) begin
              parity_error_reg <= 1'b1;
              state_reg        <= IDLE;
            end else if (bus.full) begin
              overrun_error_reg <= 1'b1;
              state_reg         <= IDLE;
            end else begin
              data_out_reg   <= shift_reg;
              data_valid_reg <= 1'b1;
              state_reg      <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + cnt_w'(1);
          end
        end

        WAIT_IDLE: begin
          // A stuck-low line or break must not retrigger a frame.
          cnt_reg <= '0;
          if (rx_s == UART_IDLE_LEVEL) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.data_out      = data_out_reg;
  assign bus.data_valid    = data_valid_reg;
  assign bus.framing_error = framing_error_reg;
  assign bus.parity_error  = parity_error_reg;
  assign bus.overrun_error = overrun_error_reg;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level outcome model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int cpb = 8;
  localparam int dw  = 8;
`ifdef UART_PARITY_EN
  localparam bit par_en = 1'b1;
`else
  localparam bit par_en = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn;

  uart_rx_if #(.data_width(dw)) bus ();

  uart_rx #(
    .clocks_per_bit (cpb),
    .data_width     (dw)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Event counters, written only by the monitor below.
  int        n_valid = 0;
  int        n_fe    = 0;
  int        n_pe    = 0;
  int        n_oe    = 0;
  logic [7:0] last_push = 8'h00;

  // Reference: last byte that should have been pushed.
  logic [7:0] model_data = 8'h00;

  // Monitor outputs away from the active edge.
  always @(negedge clock) begin
    if (bus.data_valid === 1'b1) begin
      n_valid   = n_valid + 1;
      last_push = bus.data_out;
    end
    if (bus.framing_error === 1'b1) n_fe = n_fe + 1;
    if (bus.parity_error === 1'b1)  n_pe = n_pe + 1;
    if (bus.overrun_error === 1'b1) n_oe = n_oe + 1;
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Drive one frame and check its outcome against the frame-level rules.
  task automatic run_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                           input bit full_v, input string tag);
    int v0, fe0, pe0, oe0;
    int e_v, e_fe, e_pe, e_oe;
`ifdef UART_PARITY_EN
    logic par;
`endif
    v0 = n_valid; fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
    e_v = 0; e_fe = 0; e_pe = 0; e_oe = 0;
    if (!stop_ok)               e_fe = 1;
    else if (par_en && !par_ok) e_pe = 1;
    else if (full_v)            e_oe = 1;
    else                        e_v  = 1;

    bus.full = full_v;
    bus.rx = 1'b0;
    repeat (cpb) @(negedge clock);
    for (int i = 0; i < dw; i++) begin
      bus.rx = d[i];
      repeat (cpb) @(negedge clock);
    end
`ifdef UART_PARITY_EN
    par = (^d) ^ !par_ok;
    bus.rx = par;
    repeat (cpb) @(negedge clock);
`endif
    bus.rx = stop_ok;
    repeat (cpb) @(negedge clock);

    if (e_v == 1) model_data = d;

    checks++;
    if ((n_valid - v0) !== e_v) begin
      errors++;
      $display("FAIL %s valid_count got %0d want %0d", tag, n_valid - v0, e_v);
    end
    checks++;
    if ((n_fe - fe0) !== e_fe || (n_pe - pe0) !== e_pe || (n_oe - oe0) !== e_oe) begin
      errors++;
      $display("FAIL %s error_counts fe/pe/oe got %0d/%0d/%0d want %0d/%0d/%0d",
               tag, n_fe - fe0, n_pe - pe0, n_oe - oe0, e_fe, e_pe, e_oe);
    end
    checks++;
    if (bus.data_out !== model_data) begin
      errors++;
      $display("FAIL %s data_out got %h want %h", tag, bus.data_out, model_data);
    end
    if (e_v == 1) begin
      checks++;
      if (last_push !== d) begin
        errors++;
        $display("FAIL %s pushed_byte got %h want %h", tag, last_push, d);
      end
    end
    if (stop_ok) begin
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_after got %b want 0", tag, bus.busy);
      end
    end
    $display("frame %s data=%h par_ok=%0d stop_ok=%0d full=%0d -> valid=%0d fe=%0d pe=%0d oe=%0d",
             tag, d, par_ok, stop_ok, full_v, n_valid - v0, n_fe - fe0, n_pe - pe0, n_oe - oe0);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1; bus.full = 1'b0; resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.data_out, bus.data_valid, bus.framing_error, bus.parity_error,
         bus.overrun_error, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h/%b%b%b%b%b want all 0", bus.data_out, bus.data_valid,
               bus.framing_error, bus.parity_error, bus.overrun_error, bus.busy);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || n_valid !== 0) begin
      errors++;
      $display("FAIL reset_release busy=%b valids=%0d want 0/0", bus.busy, n_valid);
    end
    $display("reset done");
  endtask

  task automatic test_single();
    int v0;
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, "single_a5");
    v0 = n_valid;
    idle(20);
    checks++;
    if (bus.data_out !== 8'hA5 || n_valid !== v0) begin
      errors++;
      $display("FAIL hold_a5 data_out got %h valids %0d want a5 %0d", bus.data_out, n_valid, v0);
    end
    $display("hold data_out=%h after 20 idle cycles", bus.data_out);
  endtask

  task automatic test_false_start();
    int v0, e0;
    bit seen_busy;
    v0 = n_valid; e0 = n_fe + n_pe + n_oe;
    seen_busy = 1'b0;
    bus.rx = 1'b0;
    repeat (2) @(negedge clock);
    bus.rx = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.busy === 1'b1) seen_busy = 1'b1;
    end
    checks++;
    if (bus.busy !== 1'b0 || seen_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy got busy=%b seen=%b want 0/1", bus.busy, seen_busy);
    end
    idle(cpb * 12);
    checks++;
    if (n_valid !== v0 || (n_fe + n_pe + n_oe) !== e0 || bus.data_out !== model_data) begin
      errors++;
      $display("FAIL glitch_events got valids=%0d errs=%0d want %0d/%0d",
               n_valid - v0, n_fe + n_pe + n_oe - e0, 0, 0);
    end
    $display("false start: busy seen=%b, no events", seen_busy);
  endtask

  task automatic test_framing();
    int v0, f0;
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, "framing_3c");
    v0 = n_valid; f0 = n_fe;
    bus.rx = 1'b0;
    repeat (3 * cpb) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1 || n_fe !== f0 || n_valid !== v0) begin
      errors++;
      $display("FAIL stuck_low busy=%b new_fe=%0d new_valid=%0d want 1/0/0",
               bus.busy, n_fe - f0, n_valid - v0);
    end
    idle(2 * cpb);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_exit busy got %b want 0", bus.busy);
    end
    run_frame(8'h55, 1'b1, 1'b1, 1'b0, "after_framing_55");
  endtask

  task automatic test_overrun();
    run_frame(8'h11, 1'b1, 1'b1, 1'b1, "overrun_11");
    run_frame(8'h22, 1'b1, 1'b1, 1'b0, "after_overrun_22");
  endtask

  task automatic test_parity();
    run_frame(8'h07, 1'b1, 1'b1, 1'b0, "parity_good_07");
    run_frame(8'h07, 1'b0, 1'b1, 1'b0, "parity_bad_07");
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit stop_ok, par_ok, full_v;
    int gap;
    for (int n = 0; n < 24; n++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok  = par_en ? ($urandom_range(0, 4) != 0) : 1'b1;
      full_v  = ($urandom_range(0, 3) == 0);
      gap     = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      run_frame(d, par_ok, stop_ok, full_v, $sformatf("rand%0d", n));
      if (gap != 0) idle(gap * cpb);
    end
    bus.full = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    run_frame(8'h5A, 1'b1, 1'b1, 1'b0, "pre_reset_5a");
    bus.rx = 1'b0;
    repeat (cpb) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b1;
      repeat (cpb) @(negedge clock);
    end
    bus.rx = 1'b1;
    repeat (cpb / 2) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.data_out, bus.data_valid, bus.framing_error, bus.parity_error,
         bus.overrun_error, bus.busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs data=%h v=%b fe=%b pe=%b oe=%b busy=%b want all 0",
               bus.data_out, bus.data_valid, bus.framing_error, bus.parity_error,
               bus.overrun_error, bus.busy);
    end
    @(negedge clock);
    resetn = 1'b1;
    model_data = 8'h00;
    v0 = n_valid;
    idle(5 * cpb);
    checks++;
    if (n_valid !== v0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset valids=%0d busy=%b want 0/0", n_valid - v0, bus.busy);
    end
    $display("mid-frame reset applied and released");
    run_frame(8'h81, 1'b1, 1'b1, 1'b0, "post_reset_81");
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    run_frame(8'h81, 1'b1, 1'b1, 1'b0, "b2b_81");
    run_frame(8'h7E, 1'b1, 1'b1, 1'b0, "b2b_7e");
    checks++;
    if ((n_valid - v0) !== 2) begin
      errors++;
      $display("FAIL b2b_total got %0d want 2", n_valid - v0);
    end
    idle(cpb);
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_framing();
    test_overrun();
    if (par_en) test_parity();
    test_random();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
